// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the pixel timing source and its consumers.
// Latency: none. Plain wires with no storage.
// Backpressure: none. The raster free-runs, and consumers sample on enable.
//
// Signals
//   pause, advance_frame  consumer -> generator: frame counter control
//   enable                pixel-rate clock enable
//   x, y                  raster position
//   active, hsync, vsync  decoded raster regions (sync active-high)
//   new_frame             one enable cycle at the last pixel of the frame
//   frame                 frame counter
interface vga_timing_gen_if #(
    parameter int FRAME_BITS = 10
);
    logic                  pause;
    logic                  advance_frame;
    logic                  enable;
    logic [9:0]            x;
    logic [9:0]            y;
    logic                  active;
    logic                  hsync;
    logic                  vsync;
    logic                  new_frame;
    logic [FRAME_BITS-1:0] frame;

    modport master (
        input  pause, advance_frame,
        output enable, x, y, active, hsync, vsync, new_frame, frame
    );

    modport slave (
        output pause, advance_frame,
        input  enable, x, y, active, hsync, vsync, new_frame, frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel timing source: pixel-rate enable, h/v raster counters, sync decodes, frame counter.
// Latency: x/y/frame update 1 clk after an enable cycle; decodes are combinational from x/y.
// Backpressure: none. The raster never stalls, and pause only holds the frame counter.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   vid.pause      hold frame counter (raster keeps running)
//   vid.advance_frame  while paused, a rising edge requests one frame step
//   vid.enable     asserted once every 2**DIV_LOG2 clk cycles
//   vid.x / vid.y  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   vid.active     x < H_ACTIVE && y < V_ACTIVE
//   vid.hsync      high across the horizontal sync pulse (active-high)
//   vid.vsync      high across the vertical sync lines (active-high)
//   vid.new_frame  high for the enable cycle at the last pixel of the frame
//   vid.frame      frame counter, wraps mod 2**FRAME_BITS
module vga_timing_gen #(
    parameter int DIV_LOG2   = 1,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FRAME_BITS = 10
) (
    input  logic            clk,
    input  logic            reset,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide. A sync pulse can end exactly at 1024
    // when the back porch is zero, which a 10-bit constant could not hold.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic                  pix_en;
    logic [9:0]            x_q;
    logic [9:0]            y_q;
    logic                  line_end;
    logic                  frame_end;
    logic                  adv_prev_q;
    logic                  adv_req_q;
    logic                  adv_rise;
    logic [FRAME_BITS-1:0] frame_q;
    logic [10:0]           x_ext;
    logic [10:0]           y_ext;

    // ------------------------------------------------------------------
    // Pixel-rate enable: fires when the divider reaches all-ones. The
    // divider restarts at zero on reset, so the first enable comes
    // 2**DIV_LOG2-1 cycles after reset is released.
    // ------------------------------------------------------------------
    generate
        if (DIV_LOG2 == 0) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] div_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + DIV_LOG2'(1);
                end
            end

            assign pix_en = &div_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    assign line_end  = (x_q == H_LAST);
    assign frame_end = pix_en && line_end && (y_q == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                x_q <= '0;
                y_q <= (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Region decodes from the registered position
    // ------------------------------------------------------------------
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    assign vid.enable    = pix_en;
    assign vid.x         = x_q;
    assign vid.y         = y_q;
    assign vid.active    = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    assign vid.hsync     = (x_ext >= HS_BEG) && (x_ext < HS_END);
    assign vid.vsync     = (y_ext >= VS_BEG) && (y_ext < VS_END);
    assign vid.new_frame = frame_end;

    // ------------------------------------------------------------------
    // Single-step request while paused. advance_frame arrives already
    // synchronised. Any number of edges within one frame collapse into a
    // single sticky request. An edge that lands on the frame-end cycle
    // itself counts toward the following frame.
    // ------------------------------------------------------------------
    assign adv_rise = vid.advance_frame & ~adv_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adv_prev_q <= 1'b0;
            adv_req_q  <= 1'b0;
        end else begin
            adv_prev_q <= vid.advance_frame;
            if (!vid.pause) begin
                adv_req_q <= 1'b0;
            end else if (frame_end) begin
                adv_req_q <= adv_rise;
            end else if (adv_rise) begin
                adv_req_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
        end else if (frame_end && (!vid.pause || adv_req_q)) begin
            frame_q <= frame_q + FRAME_BITS'(1);
        end
    end

    assign vid.frame = frame_q;

endmodule
